// File: rtl/sdp_ram_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module      : sdp_ram_pkg                                                |
// | Description : Shared default widths and word/address types for the       |
// |               simple dual-port RAM.                                      |
// | Revision    : 1.0 - initial release                                      |
// ----------------------------------------------------------------------------
package sdp_ram_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;

endpackage : sdp_ram_pkg
`default_nettype wire

// File: rtl/sdp_ram_mem.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module      : sdp_ram_mem                                                |
// | Description : Raw storage array: one synchronous write port and one      |
// |               unregistered (combinational) read port. Contents are never |
// |               cleared.                                                   |
// | Revision    : 1.0 - initial release                                      |
// ----------------------------------------------------------------------------
module sdp_ram_mem
  import sdp_ram_pkg::*;
#(
  parameter int DATA_W = sdp_ram_pkg::DATA_W,
  parameter int ADDR_W = sdp_ram_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int c_DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [0:c_DEPTH-1];

  // Storage update; no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Asynchronous read: the caller registers the result, which gives read-first
  // behaviour on a same-address write in the same cycle.
  assign rd_data = r_mem[rd_addr];

endmodule : sdp_ram_mem
`default_nettype wire

// File: rtl/simple_dual_port_ram.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module      : simple_dual_port_ram                                       |
// | Description : Simple dual-port synchronous RAM. Port A writes, port B    |
// |               reads with one clock of latency. A global chip enable      |
// |               idles both ports. dout clears asynchronously on rst.       |
// |               Build option SDP_WRITE_FIRST_EN: on a same-address         |
// |               write/read collision dout returns din (write-through)      |
// |               instead of the old contents.                               |
// | Revision    : 1.0 - initial release                                      |
// ----------------------------------------------------------------------------
module simple_dual_port_ram
  import sdp_ram_pkg::*;
#(
  parameter int DATA_W = sdp_ram_pkg::DATA_W,
  parameter int ADDR_W = sdp_ram_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              ce,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] adr_a,
  input  logic [ADDR_W-1:0] adr_b,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic              w_wr_en;
  logic              w_rd_en;
  logic [DATA_W-1:0] w_rd_data;
  logic [DATA_W-1:0] r_rd_data;

  // Port enables; writes are suppressed while reset is held.
  always_comb begin
    w_wr_en = ce & we & ~rst;
    w_rd_en = ce & re;
  end

  sdp_ram_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (w_wr_en),
    .wr_addr (adr_a),
    .wr_data (din),
    .rd_addr (adr_b),
    .rd_data (w_rd_data)
  );

  // Read data register: clears at once on reset, holds when the read port idles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data <= '0;
    end else if (w_rd_en) begin
      r_rd_data <= w_rd_data;
    end
  end

`ifdef SDP_WRITE_FIRST_EN
  logic              r_collide;
  logic [DATA_W-1:0] r_bypass;

  // Remember whether the last performed read collided with a write, and the
  // word being written; both hold with dout when the read port idles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_collide <= 1'b0;
      r_bypass  <= '0;
    end else if (w_rd_en) begin
      r_collide <= we & (adr_a == adr_b);
      r_bypass  <= din;
    end
  end

  // Write-through: a collided read returns the new word.
  always_comb begin
    dout = r_collide ? r_bypass : r_rd_data;
  end
`else
  // Read-first: a collided read returns the old contents.
  always_comb begin
    dout = r_rd_data;
  end
`endif

endmodule : simple_dual_port_ram
`default_nettype wire

// File: tb/tb_simple_dual_port_ram.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module      : tb_simple_dual_port_ram                                    |
// | Description : Directed self-checking bench for simple_dual_port_ram.     |
// |               Expected read data is queued when a read is issued and     |
// |               compared one clock later. Honours SDP_WRITE_FIRST_EN for   |
// |               the collision expectation.                                 |
// | Revision    : 1.0 - initial release                                      |
// ----------------------------------------------------------------------------
module tb_simple_dual_port_ram;

  logic       clk;
  logic       ce;
  logic       rst;
  logic       we;
  logic       re;
  logic [7:0] adr_a;
  logic [7:0] adr_b;
  logic [7:0] din;
  logic [7:0] dout;

  int tests_run;
  int tests_failed;

  logic [7:0] exp_q [$];

  simple_dual_port_ram #(
    .DATA_W (8),
    .ADDR_W (8)
  ) dut (
    .clk   (clk),
    .ce    (ce),
    .rst   (rst),
    .we    (we),
    .re    (re),
    .adr_a (adr_a),
    .adr_b (adr_b),
    .din   (din),
    .dout  (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard bound on simulation time.
  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs (we are at a negedge), optionally queue the
  // expected dout after this edge, then compare at the following negedge.
  task automatic cycle(input string tag,
                       input logic c, input logic w, input logic r,
                       input logic [7:0] aa, input logic [7:0] ab,
                       input logic [7:0] d,
                       input logic chk, input logic [7:0] exp);
    logic [7:0] e;
    ce = c; we = w; re = r; adr_a = aa; adr_b = ab; din = d;
    if (chk) exp_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(tag, dout, e);
    end
  endtask

  initial begin
    logic [7:0] coll_exp;
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1; ce = 1'b0; we = 1'b0; re = 1'b0;
    adr_a = '0; adr_b = '0; din = '0;

    repeat (2) @(negedge clk);
    check("reset_dout", dout, 8'h00);
    rst = 1'b0;

    // Write then read
    cycle("wr_2_at_1",   1, 1, 0, 8'd1, 8'd0, 8'd2, 0, 8'h00);
    cycle("wr_3_at_2",   1, 1, 0, 8'd2, 8'd0, 8'd3, 0, 8'h00);
    cycle("rd_1",        1, 0, 1, 8'd0, 8'd1, 8'd0, 1, 8'd2);
    cycle("rd_2",        1, 0, 1, 8'd0, 8'd2, 8'd0, 1, 8'd3);

    // Pipelined write/read
    cycle("pipe_rd_1",   1, 1, 1, 8'd3, 8'd1, 8'd4, 1, 8'd2);
    cycle("pipe_rd_2",   1, 1, 1, 8'd4, 8'd2, 8'd5, 1, 8'd3);
    cycle("pipe_rd_3",   1, 1, 1, 8'd5, 8'd3, 8'd6, 1, 8'd4);
    cycle("rd_4",        1, 0, 1, 8'd0, 8'd4, 8'd0, 1, 8'd5);

    // we=0 must not write
    cycle("wr_5a_at_6",  1, 1, 0, 8'd6, 8'd0, 8'h5A, 0, 8'h00);
    cycle("we0_attempt", 1, 0, 0, 8'd6, 8'd0, 8'd7,  0, 8'h00);
    cycle("rd_6_we0",    1, 0, 1, 8'd0, 8'd6, 8'd0,  1, 8'h5A);

    // ce=0 blocks both ports
    cycle("ce0_hold",    0, 1, 1, 8'd3, 8'd3, 8'hEE, 1, 8'h5A);
    cycle("rd_3_ce0",    1, 0, 1, 8'd0, 8'd3, 8'd0,  1, 8'd4);

    // re=0 holds dout
    cycle("re0_hold",    1, 0, 0, 8'd0, 8'd1, 8'd0,  1, 8'd4);

    // Async reset between edges; writes blocked while held
    #1;
    rst = 1'b1;
    #1;
    check("async_rst", dout, 8'h00);
    @(negedge clk);
    cycle("rst_wr_blk",  1, 1, 1, 8'd1, 8'd2, 8'h99, 1, 8'h00);
    rst = 1'b0;
    cycle("rd_1_post",   1, 0, 1, 8'd0, 8'd1, 8'd0,  1, 8'd2);

    // Collision
`ifdef SDP_WRITE_FIRST_EN
    coll_exp = 8'h22;
`else
    coll_exp = 8'h11;
`endif
    cycle("wr_11_at_9",  1, 1, 0, 8'd9, 8'd0, 8'h11, 0, 8'h00);
    cycle("collide_9",   1, 1, 1, 8'd9, 8'd9, 8'h22, 1, coll_exp);
    cycle("collide_hold",1, 0, 0, 8'd0, 8'd0, 8'h00, 1, coll_exp);
    cycle("rd_9_after",  1, 0, 1, 8'd0, 8'd9, 8'd0,  1, 8'h22);

    // Address range extremes
    cycle("wr_a5_at_ff", 1, 1, 0, 8'd255, 8'd0, 8'hA5, 0, 8'h00);
    cycle("wr_3c_at_0",  1, 1, 0, 8'd0,   8'd0, 8'h3C, 0, 8'h00);
    cycle("rd_ff",       1, 0, 1, 8'd0, 8'd255, 8'd0,  1, 8'hA5);
    cycle("rd_0",        1, 0, 1, 8'd0, 8'd0,   8'd0,  1, 8'h3C);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_simple_dual_port_ram
`default_nettype wire
